// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two 2-entry result queues (FU1, FU2) share one
// registered CDB broadcast slot, granted round-robin, one result per cycle.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              fu1_valid,
    input  logic [TAG_W-1:0]  fu1_tag,
    input  logic [DATA_W-1:0] fu1_data,
    output logic              fu1_ready,
    input  logic              fu2_valid,
    input  logic [TAG_W-1:0]  fu2_tag,
    input  logic [DATA_W-1:0] fu2_data,
    output logic              fu2_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_src
);
    localparam int ENT_W = TAG_W + DATA_W;
    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef enum logic {RR_FU1 = 1'b0, RR_FU2 = 1'b1} rr_e;

    logic [ENT_W-1:0] r_mem [2][DEPTH];
    logic             r_wp  [2];
    logic             r_rp  [2];
    logic [1:0]       r_cnt [2];
    rr_e              r_rr;

    logic             w_valid [2];
    logic [ENT_W-1:0] w_in    [2];
    logic [ENT_W-1:0] w_head  [2];
    logic             w_ne    [2];
    logic             w_push  [2];
    logic             w_pop   [2];

    // Ready depends only on registered occupancy, never on valid.
    assign fu1_ready = (r_cnt[0] < FULL);
    assign fu2_ready = (r_cnt[1] < FULL);

    always_comb begin
        w_valid[0] = fu1_valid;
        w_valid[1] = fu2_valid;
        w_in[0]    = {fu1_tag, fu1_data};
        w_in[1]    = {fu2_tag, fu2_data};
        for (int unsigned u = 0; u < 2; u++) begin
            w_ne[u]   = (r_cnt[u] != 2'd0);
            w_push[u] = w_valid[u] && (r_cnt[u] < FULL);
            w_head[u] = r_mem[u][r_rp[u]];
        end
        w_pop[0] = w_ne[0] && (!w_ne[1] || (r_rr == RR_FU1));
        w_pop[1] = w_ne[1] && (!w_ne[0] || (r_rr == RR_FU2));
    end

    // Queue storage carries no reset; occupancy state alone decides validity.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            for (int unsigned u = 0; u < 2; u++) begin
                if (w_push[u]) r_mem[u][r_wp[u]] <= w_in[u];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned u = 0; u < 2; u++) begin
                r_wp[u]  <= 1'b0;
                r_rp[u]  <= 1'b0;
                r_cnt[u] <= '0;
            end
            r_rr      <= RR_FU1;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= 1'b0;
        end else if (flush) begin
            for (int unsigned u = 0; u < 2; u++) begin
                r_wp[u]  <= 1'b0;
                r_rp[u]  <= 1'b0;
                r_cnt[u] <= '0;
            end
            r_rr      <= RR_FU1;
            cdb_valid <= 1'b0;
        end else begin
            for (int unsigned u = 0; u < 2; u++) begin
                if (w_push[u]) r_wp[u] <= ~r_wp[u];
                if (w_pop[u])  r_rp[u] <= ~r_rp[u];
                r_cnt[u] <= r_cnt[u] + {1'b0, w_push[u]} - {1'b0, w_pop[u]};
            end
            cdb_valid <= w_pop[0] || w_pop[1];
            if (w_pop[0]) begin
                {cdb_tag, cdb_data} <= w_head[0];
                cdb_src             <= 1'b0;
                r_rr                <= RR_FU2;
            end else if (w_pop[1]) begin
                {cdb_tag, cdb_data} <= w_head[1];
                cdb_src             <= 1'b1;
                r_rr                <= RR_FU1;
            end
        end
    end
endmodule
